// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: receive-byte handshake bundle (rx_data/rx_valid/rx_ready plus qualifying flags); master = receiver, slave = consumer
interface uart_rx_ctrl_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic frame_err;
  logic parity_err;
  logic overrun;
  modport master(output rx_data, rx_valid, frame_err, parity_err, overrun, input rx_ready);
  modport slave(input rx_data, rx_valid, frame_err, parity_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 16x oversampled UART receiver; clk, rst_n (async active-low), rx_in (raw line), busy, io (rx byte handshake + frame_err/parity_err/overrun); define UART_RX_PARITY_EN for an even-parity bit
module uart_rx_ctrl #(
  parameter int BAUD_DIV = 27,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic busy,
  uart_rx_ctrl_if.master io
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic s1, s2, prev;
  logic [15:0] tcnt;
  logic [3:0] scnt;
  logic [BW-1:0] bcnt;
  logic [DATA_W-1:0] sh, data_q;
  logic valid_q, ferr_q, ovr_q;
  logic tick, mid, full, fall, arm, done, load;
  assign tick = tcnt == 16'(BAUD_DIV - 1);
  assign mid = tick && scnt == 4'd7;
  assign full = tick && scnt == 4'd15;
  assign fall = prev && !s2;
  assign arm = state_q == IDLE && fall;
  assign done = state_q == STOP && full;
  // a finished frame only lands if the output slot is empty or being emptied this cycle
  assign load = done && (!valid_q || io.rx_ready);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = fall ? START : IDLE;
      START:  state_d = mid ? (s2 ? IDLE : DATA) : START;
      DATA:   state_d = (full && bcnt == BW'(DATA_W - 1)) ? AFTER_DATA : DATA;
      PARITY: state_d = full ? STOP : PARITY;
      STOP:   state_d = full ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      state_q <= IDLE;
      busy <= 1'b0;
      tcnt <= '0;
      scnt <= '0;
      bcnt <= '0;
      sh <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      s1 <= rx_in;
      s2 <= s1;
      prev <= s2;
      state_q <= state_d;
      busy <= state_d != IDLE;
      tcnt <= (arm || tick) ? '0 : tcnt + 16'd1;
      scnt <= (arm || (state_q == START && mid)) ? '0 : tick ? scnt + 4'd1 : scnt;
      if (state_q == START && mid) bcnt <= '0;
      else if (state_q == DATA && full) bcnt <= bcnt + 1'b1;
      if (state_q == DATA && full) sh <= {s2, sh[DATA_W-1:1]};
      if (load) begin
        data_q <= sh;
        ferr_q <= !s2;
      end
      valid_q <= load || (valid_q && !io.rx_ready);
      ovr_q <= (done && valid_q && !io.rx_ready) || (ovr_q && !(valid_q && io.rx_ready));
    end
  end
`ifdef UART_RX_PARITY_EN
  logic par_q, perr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (state_q == PARITY && full) par_q <= s2;
      if (load) perr_q <= ^sh ^ par_q;
    end
  end
  assign io.parity_err = perr_q;
`else
  assign io.parity_err = 1'b0;
`endif
  assign io.rx_data = data_q;
  assign io.rx_valid = valid_q;
  assign io.frame_err = ferr_q;
  assign io.overrun = ovr_q;
endmodule
